// File: rtl/arp_eth_rx_match_pkg.sv
// Shared ARP constants, FSM encodings and header layout for the ARP receive matcher.
package arp_eth_rx_match_pkg;

  // ARP over Ethernet/IPv4 constants
  localparam logic [15:0] ARP_ETHERTYPE    = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH     = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4    = 8'd4;
  localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;
  localparam int          ARP_HDR_BYTES    = 28;

  // Beat pointer width: enough for one beat per header byte plus a saturated value
  localparam int ARP_PTR_W = 5;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HDR   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // Field order matches wire order, so a 224-bit header with byte 0 in the
  // MSBs casts directly onto this struct.
  typedef struct packed {
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_hdr_t;

  // True when the Ethernet type and the fixed ARP fields describe Ethernet/IPv4 ARP
  function automatic logic arp_hdr_ok(input arp_hdr_t h, input logic [15:0] eth_type);
    return (eth_type == ARP_ETHERTYPE) &&
           (h.htype == ARP_HTYPE_ETH) &&
           (h.ptype == ARP_PTYPE_IPV4) &&
           (h.hlen == ARP_HLEN_ETH) &&
           (h.plen == ARP_PLEN_IPV4) &&
           ((h.oper == ARP_OPER_REQUEST) || (h.oper == ARP_OPER_REPLY));
  endfunction

endpackage

// File: rtl/arp_hdr_byte_sel.sv
// Picks ARP header byte byte_idx out of the current payload beat, if that
// beat (ptr) carries it and its tkeep lane is set.
module arp_hdr_byte_sel
  import arp_eth_rx_match_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic [ARP_PTR_W-1:0]  byte_idx,
  input  logic [ARP_PTR_W-1:0]  ptr,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic [KEEP_WIDTH-1:0] tkeep,
  output logic [7:0]            byte_o,
  output logic                  hit
);

  logic [ARP_PTR_W-1:0] beat_idx;
  logic [ARP_PTR_W-1:0] lane_idx;
  logic                 keep_bit;

  // Lane mux written as a compare loop so every index stays in range for any width
  always_comb begin
    beat_idx = byte_idx / ARP_PTR_W'(KEEP_WIDTH);
    lane_idx = byte_idx % ARP_PTR_W'(KEEP_WIDTH);
    byte_o   = 8'h00;
    keep_bit = 1'b0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (lane_idx == ARP_PTR_W'(i)) begin
        byte_o   = tdata[i*8 +: 8];
        keep_bit = tkeep[i];
      end
    end
    hit = keep_bit && (ptr == beat_idx);
  end

endmodule

// File: rtl/arp_eth_rx_match.sv
// ARP receive matcher: takes an Ethernet header plus payload stream, extracts
// the 28-byte ARP header, validates it, classifies it against the local
// MAC/IP and presents the decoded frame on a valid/ready output.
module arp_eth_rx_match
  import arp_eth_rx_match_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int FILTER_MODE = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,
  output logic                  m_frame_valid,
  input  logic                  m_frame_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_arp_oper,
  output logic [47:0]           m_arp_sha,
  output logic [31:0]           m_arp_spa,
  output logic [47:0]           m_arp_tha,
  output logic [31:0]           m_arp_tpa,
  output logic                  m_ip_match,
  output logic                  m_mac_match,
  output logic                  m_is_request,
  output logic                  m_is_gratuitous,
  input  logic [47:0]           local_mac,
  input  logic [31:0]           local_ip,
  output logic                  busy,
  output logic                  error_header_early_termination,
  output logic                  error_invalid_header,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  localparam int                   HDR_BEATS = (ARP_HDR_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
  localparam logic [ARP_PTR_W-1:0] PTR_MAX   = ARP_PTR_W'(HDR_BEATS);

  // Control state
  logic [1:0]                 state_q, state_d;
  logic [ARP_PTR_W-1:0]       ptr_q, ptr_d;
  logic                       got_last_q, got_last_d;
  logic                       armed_q;

  // Header capture
  logic [ARP_HDR_BYTES*8-1:0] hdr_q, hdr_d;
  logic [47:0]                eth_dest_q, eth_dest_d;
  logic [47:0]                eth_src_q, eth_src_d;
  logic [15:0]                eth_type_q, eth_type_d;

  // Output registers
  logic                       m_valid_q, m_valid_d;
  logic [47:0]                out_dest_q, out_dest_d;
  logic [47:0]                out_src_q, out_src_d;
  logic [15:0]                out_oper_q, out_oper_d;
  logic [47:0]                out_sha_q, out_sha_d;
  logic [31:0]                out_spa_q, out_spa_d;
  logic [47:0]                out_tha_q, out_tha_d;
  logic [31:0]                out_tpa_q, out_tpa_d;
  logic                       out_ip_q, out_ip_d;
  logic                       out_mac_q, out_mac_d;
  logic                       out_req_q, out_req_d;
  logic                       out_grat_q, out_grat_d;
  logic                       err_early_q, err_early_d;
  logic                       err_inv_q, err_inv_d;
  logic [CNT_WIDTH-1:0]       drop_q, drop_d;
  logic                       drop_ev;

  // Datapath helpers
  logic [KEEP_WIDTH-1:0]      keep_eff;
  logic                       hdr_hs;
  logic                       beat_hs;
  logic [ARP_HDR_BYTES-1:0]   byte_hit;
  logic [7:0]                 byte_val [ARP_HDR_BYTES];
  arp_hdr_t                   hdr_f;
  logic                       hdr_ok_c;
  logic                       ip_match_c;
  logic                       mac_match_c;

  // With tkeep disabled every lane counts as present
  assign keep_eff = s_eth_payload_axis_tkeep | {KEEP_WIDTH{KEEP_ENABLE == 0}};

  // armed_q keeps the header side closed while reset is (or was just) asserted
  assign s_eth_hdr_ready           = armed_q && (state_q == ST_IDLE) && (!m_valid_q || m_frame_ready);
  assign s_eth_payload_axis_tready = (state_q == ST_HDR) || (state_q == ST_DRAIN);
  assign hdr_hs                    = s_eth_hdr_valid && s_eth_hdr_ready;
  assign beat_hs                   = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
  assign busy                      = (state_q != ST_IDLE);

  // One selector per header byte; each watches for its own beat/lane
  generate
    for (genvar gi = 0; gi < ARP_HDR_BYTES; gi++) begin : g_byte
      arp_hdr_byte_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
      ) u_sel (
        .byte_idx (ARP_PTR_W'(gi)),
        .ptr      (ptr_q),
        .tdata    (s_eth_payload_axis_tdata),
        .tkeep    (keep_eff),
        .byte_o   (byte_val[gi]),
        .hit      (byte_hit[gi])
      );
    end
  endgenerate

  // Header capture: reset the capture on a new Ethernet header, then fill bytes per beat
  always_comb begin
    hdr_d      = hdr_q;
    ptr_d      = ptr_q;
    got_last_d = got_last_q;
    eth_dest_d = eth_dest_q;
    eth_src_d  = eth_src_q;
    eth_type_d = eth_type_q;
    if (hdr_hs) begin
      hdr_d      = '0;
      ptr_d      = '0;
      got_last_d = 1'b0;
      eth_dest_d = s_eth_dest_mac;
      eth_src_d  = s_eth_src_mac;
      eth_type_d = s_eth_type;
    end else if (beat_hs) begin
      for (int i = 0; i < ARP_HDR_BYTES; i++) begin
        if (byte_hit[i]) begin
          hdr_d[(ARP_HDR_BYTES-1-i)*8 +: 8] = byte_val[i];
        end
      end
      got_last_d = got_last_q || byte_hit[ARP_HDR_BYTES-1];
      if (ptr_q != PTR_MAX) begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  // Decode uses hdr_d so a header completing on the tlast beat is seen at once
  assign hdr_f       = arp_hdr_t'(hdr_d);
  assign hdr_ok_c    = arp_hdr_ok(hdr_f, eth_type_q);
  assign ip_match_c  = (hdr_f.tpa == local_ip);
  assign mac_match_c = (hdr_f.tha == local_mac) || (hdr_f.tha == 48'h0);

  // FSM, frame disposition on tlast, output register loads and drop counting
  always_comb begin
    state_d     = state_q;
    m_valid_d   = m_valid_q;
    out_dest_d  = out_dest_q;
    out_src_d   = out_src_q;
    out_oper_d  = out_oper_q;
    out_sha_d   = out_sha_q;
    out_spa_d   = out_spa_q;
    out_tha_d   = out_tha_q;
    out_tpa_d   = out_tpa_q;
    out_ip_d    = out_ip_q;
    out_mac_d   = out_mac_q;
    out_req_d   = out_req_q;
    out_grat_d  = out_grat_q;
    err_early_d = 1'b0;
    err_inv_d   = 1'b0;
    drop_ev     = 1'b0;
    drop_d      = drop_q;

    if (m_valid_q && m_frame_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (hdr_hs) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR, ST_DRAIN: begin
        if (beat_hs) begin
          if (s_eth_payload_axis_tlast) begin
            state_d = ST_IDLE;
            if (s_eth_payload_axis_tuser) begin
              drop_ev = 1'b1;
            end else if (!got_last_d) begin
              err_early_d = 1'b1;
              drop_ev     = 1'b1;
            end else if (!hdr_ok_c) begin
              err_inv_d = 1'b1;
              drop_ev   = 1'b1;
            end else if ((FILTER_MODE != 0) && !ip_match_c) begin
              drop_ev = 1'b1;
            end else begin
              m_valid_d  = 1'b1;
              out_dest_d = eth_dest_q;
              out_src_d  = eth_src_q;
              out_oper_d = hdr_f.oper;
              out_sha_d  = hdr_f.sha;
              out_spa_d  = hdr_f.spa;
              out_tha_d  = hdr_f.tha;
              out_tpa_d  = hdr_f.tpa;
              out_ip_d   = ip_match_c;
              out_mac_d  = mac_match_c;
              out_req_d  = (hdr_f.oper == ARP_OPER_REQUEST);
              out_grat_d = (hdr_f.spa == hdr_f.tpa);
            end
          end else if (got_last_d) begin
            state_d = ST_DRAIN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (drop_ev && (drop_q != {CNT_WIDTH{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      got_last_q  <= 1'b0;
      armed_q     <= 1'b0;
      hdr_q       <= '0;
      eth_dest_q  <= '0;
      eth_src_q   <= '0;
      eth_type_q  <= '0;
      m_valid_q   <= 1'b0;
      out_dest_q  <= '0;
      out_src_q   <= '0;
      out_oper_q  <= '0;
      out_sha_q   <= '0;
      out_spa_q   <= '0;
      out_tha_q   <= '0;
      out_tpa_q   <= '0;
      out_ip_q    <= 1'b0;
      out_mac_q   <= 1'b0;
      out_req_q   <= 1'b0;
      out_grat_q  <= 1'b0;
      err_early_q <= 1'b0;
      err_inv_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      got_last_q  <= got_last_d;
      armed_q     <= 1'b1;
      hdr_q       <= hdr_d;
      eth_dest_q  <= eth_dest_d;
      eth_src_q   <= eth_src_d;
      eth_type_q  <= eth_type_d;
      m_valid_q   <= m_valid_d;
      out_dest_q  <= out_dest_d;
      out_src_q   <= out_src_d;
      out_oper_q  <= out_oper_d;
      out_sha_q   <= out_sha_d;
      out_spa_q   <= out_spa_d;
      out_tha_q   <= out_tha_d;
      out_tpa_q   <= out_tpa_d;
      out_ip_q    <= out_ip_d;
      out_mac_q   <= out_mac_d;
      out_req_q   <= out_req_d;
      out_grat_q  <= out_grat_d;
      err_early_q <= err_early_d;
      err_inv_q   <= err_inv_d;
      drop_q      <= drop_d;
    end
  end

  assign m_frame_valid                  = m_valid_q;
  assign m_eth_dest_mac                 = out_dest_q;
  assign m_eth_src_mac                  = out_src_q;
  assign m_arp_oper                     = out_oper_q;
  assign m_arp_sha                      = out_sha_q;
  assign m_arp_spa                      = out_spa_q;
  assign m_arp_tha                      = out_tha_q;
  assign m_arp_tpa                      = out_tpa_q;
  assign m_ip_match                     = out_ip_q;
  assign m_mac_match                    = out_mac_q;
  assign m_is_request                   = out_req_q;
  assign m_is_gratuitous                = out_grat_q;
  assign error_header_early_termination = err_early_q;
  assign error_invalid_header           = err_inv_q;
  assign drop_count                     = drop_q;

endmodule

// File: tb/tb_arp_eth_rx_match.sv
// Bench for arp_eth_rx_match: an 8-bit unfiltered instance (A) driven from a
// vector table, and a 64-bit filtering instance with a 2-bit drop counter (B)
// for backpressure, back-to-back and saturation sequences.
module tb_arp_eth_rx_match;

  localparam logic [47:0] LMAC = 48'h020000000001;
  localparam logic [31:0] LIP  = 32'hC0A8010A;
  localparam logic [47:0] SHA  = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] SMAC = 48'h021122334455;

  logic clk, rst_n;
  logic [47:0] local_mac;
  logic [31:0] local_ip;

  // Instance A signals
  logic a_hdr_valid, a_hdr_ready, a_tvalid, a_tready, a_tlast, a_tuser;
  logic [47:0] a_dest, a_src;
  logic [15:0] a_type;
  logic [7:0] a_tdata;
  logic [0:0] a_tkeep;
  logic a_m_valid, a_m_ready, a_ip, a_mac, a_req, a_grat, a_busy, a_err_early, a_err_inv;
  logic [47:0] a_o_dest, a_o_src, a_o_sha, a_o_tha;
  logic [15:0] a_o_oper;
  logic [31:0] a_o_spa, a_o_tpa;
  logic [15:0] a_drop;

  // Instance B signals
  logic b_hdr_valid, b_hdr_ready, b_tvalid, b_tready, b_tlast, b_tuser;
  logic [47:0] b_dest, b_src;
  logic [15:0] b_type;
  logic [63:0] b_tdata;
  logic [7:0] b_tkeep;
  logic b_m_valid, b_m_ready, b_ip, b_mac, b_req, b_grat, b_busy, b_err_early, b_err_inv;
  logic [47:0] b_o_dest, b_o_src, b_o_sha, b_o_tha;
  logic [15:0] b_o_oper;
  logic [31:0] b_o_spa, b_o_tpa;
  logic [1:0] b_drop;

  int checks = 0;
  int failures = 0;
  logic [7:0] fb [0:63];

  typedef struct {
    string       name;
    logic [15:0] et;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [15:0] oper;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
    int          len;
    logic        user;
    logic        e_valid, e_early, e_inv, e_ip, e_mac, e_req, e_grat;
    int          e_drop;
  } vec_t;

  vec_t vecs [10];

  arp_eth_rx_match #(.DATA_WIDTH(8), .FILTER_MODE(0), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_eth_hdr_valid(a_hdr_valid), .s_eth_hdr_ready(a_hdr_ready),
    .s_eth_dest_mac(a_dest), .s_eth_src_mac(a_src), .s_eth_type(a_type),
    .s_eth_payload_axis_tdata(a_tdata), .s_eth_payload_axis_tkeep(a_tkeep),
    .s_eth_payload_axis_tvalid(a_tvalid), .s_eth_payload_axis_tready(a_tready),
    .s_eth_payload_axis_tlast(a_tlast), .s_eth_payload_axis_tuser(a_tuser),
    .m_frame_valid(a_m_valid), .m_frame_ready(a_m_ready),
    .m_eth_dest_mac(a_o_dest), .m_eth_src_mac(a_o_src), .m_arp_oper(a_o_oper),
    .m_arp_sha(a_o_sha), .m_arp_spa(a_o_spa), .m_arp_tha(a_o_tha), .m_arp_tpa(a_o_tpa),
    .m_ip_match(a_ip), .m_mac_match(a_mac), .m_is_request(a_req), .m_is_gratuitous(a_grat),
    .local_mac(local_mac), .local_ip(local_ip), .busy(a_busy),
    .error_header_early_termination(a_err_early), .error_invalid_header(a_err_inv),
    .drop_count(a_drop)
  );

  arp_eth_rx_match #(.DATA_WIDTH(64), .FILTER_MODE(1), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_eth_hdr_valid(b_hdr_valid), .s_eth_hdr_ready(b_hdr_ready),
    .s_eth_dest_mac(b_dest), .s_eth_src_mac(b_src), .s_eth_type(b_type),
    .s_eth_payload_axis_tdata(b_tdata), .s_eth_payload_axis_tkeep(b_tkeep),
    .s_eth_payload_axis_tvalid(b_tvalid), .s_eth_payload_axis_tready(b_tready),
    .s_eth_payload_axis_tlast(b_tlast), .s_eth_payload_axis_tuser(b_tuser),
    .m_frame_valid(b_m_valid), .m_frame_ready(b_m_ready),
    .m_eth_dest_mac(b_o_dest), .m_eth_src_mac(b_o_src), .m_arp_oper(b_o_oper),
    .m_arp_sha(b_o_sha), .m_arp_spa(b_o_spa), .m_arp_tha(b_o_tha), .m_arp_tpa(b_o_tpa),
    .m_ip_match(b_ip), .m_mac_match(b_mac), .m_is_request(b_req), .m_is_gratuitous(b_grat),
    .local_mac(local_mac), .local_ip(local_ip), .busy(b_busy),
    .error_header_early_termination(b_err_early), .error_invalid_header(b_err_inv),
    .drop_count(b_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [15:0] et, input logic [15:0] ptype,
                              input logic [7:0] hlen, input logic [15:0] oper, input logic [31:0] spa,
                              input logic [47:0] tha, input logic [31:0] tpa, input int len,
                              input logic user, input logic ev, input logic ee, input logic ei,
                              input logic eip, input logic emac, input logic ereq, input logic egrat,
                              input int edrop);
    vec_t v;
    v.name = nm; v.et = et; v.ptype = ptype; v.hlen = hlen; v.oper = oper;
    v.spa = spa; v.tha = tha; v.tpa = tpa; v.len = len; v.user = user;
    v.e_valid = ev; v.e_early = ee; v.e_inv = ei; v.e_ip = eip;
    v.e_mac = emac; v.e_req = ereq; v.e_grat = egrat; v.e_drop = edrop;
    return v;
  endfunction

  // Wire-order ARP header into fb[0..27], counting pattern as padding
  task automatic fill_frame(input logic [15:0] ptype, input logic [7:0] hlen, input logic [15:0] oper,
                            input logic [31:0] spa, input logic [47:0] tha, input logic [31:0] tpa);
    logic [223:0] h;
    h = {16'h0001, ptype, hlen, 8'd4, oper, SHA, spa, tha, tpa};
    for (int i = 0; i < 64; i++) begin
      if (i < 28) fb[i] = h[223-8*i -: 8];
      else fb[i] = 8'(i);
    end
  endtask

  task automatic a_hdr(input logic [15:0] et);
    int n;
    a_hdr_valid = 1'b1; a_type = et; a_dest = LMAC; a_src = SMAC;
    n = 0;
    @(negedge clk);
    while (!a_hdr_ready && n < 100) begin n++; @(negedge clk); end
    if (!a_hdr_ready) chk("a_hdr_timeout", 64'(a_hdr_ready), 64'd1);
    @(posedge clk); #1;
    a_hdr_valid = 1'b0;
  endtask

  task automatic a_beat(input logic [7:0] d, input logic last, input logic user);
    int n;
    a_tvalid = 1'b1; a_tdata = d; a_tlast = last; a_tuser = user;
    n = 0;
    @(negedge clk);
    while (!a_tready && n < 100) begin n++; @(negedge clk); end
    if (!a_tready) chk("a_beat_timeout", 64'(a_tready), 64'd1);
    @(posedge clk); #1;
    a_tvalid = 1'b0; a_tlast = 1'b0; a_tuser = 1'b0;
  endtask

  task automatic a_payload(input int len, input logic user);
    for (int i = 0; i < len; i++) a_beat(fb[i], (i == len - 1), user && (i == len - 1));
  endtask

  task automatic b_hdr(input logic [15:0] et);
    int n;
    b_hdr_valid = 1'b1; b_type = et; b_dest = LMAC; b_src = SMAC;
    n = 0;
    @(negedge clk);
    while (!b_hdr_ready && n < 100) begin n++; @(negedge clk); end
    if (!b_hdr_ready) chk("b_hdr_timeout", 64'(b_hdr_ready), 64'd1);
    @(posedge clk); #1;
    b_hdr_valid = 1'b0;
  endtask

  task automatic b_payload(input int len, input logic user);
    int nb, n;
    nb = (len + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      b_tdata = '0; b_tkeep = '0;
      for (int l = 0; l < 8; l++) begin
        if (b*8 + l < len) begin
          b_tdata[l*8 +: 8] = fb[b*8 + l];
          b_tkeep[l] = 1'b1;
        end
      end
      b_tvalid = 1'b1; b_tlast = (b == nb - 1); b_tuser = user && (b == nb - 1);
      n = 0;
      @(negedge clk);
      while (!b_tready && n < 100) begin n++; @(negedge clk); end
      if (!b_tready) chk("b_beat_timeout", 64'(b_tready), 64'd1);
      @(posedge clk); #1;
      b_tvalid = 1'b0; b_tlast = 1'b0; b_tuser = 1'b0;
    end
  endtask

  initial begin
    int exp_d;
    rst_n = 1'b0;
    local_mac = LMAC; local_ip = LIP;
    a_hdr_valid = 0; a_dest = 0; a_src = 0; a_type = 0; a_tdata = 0; a_tkeep = 1'b1;
    a_tvalid = 0; a_tlast = 0; a_tuser = 0; a_m_ready = 0;
    b_hdr_valid = 0; b_dest = 0; b_src = 0; b_type = 0; b_tdata = 0; b_tkeep = 0;
    b_tvalid = 0; b_tlast = 0; b_tuser = 0; b_m_ready = 0;

    //        name       et       ptype    hlen oper   spa           tha              tpa           len usr  v  ee ei ip mac req grat drop
    vecs[0] = mk("req_local", 16'h0806, 16'h0800, 6, 16'd1, 32'hC0A80101, 48'h0,           32'hC0A8010A, 28, 0, 1, 0, 0, 1, 1, 1, 0, 0);
    vecs[1] = mk("reply_pad", 16'h0806, 16'h0800, 6, 16'd2, 32'hC0A80102, LMAC,            32'h0A000005, 42, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    vecs[2] = mk("gratuitous",16'h0806, 16'h0800, 6, 16'd1, 32'hC0A8010A, 48'h112233445566, 32'hC0A8010A, 28, 0, 1, 0, 0, 1, 0, 1, 1, 0);
    vecs[3] = mk("early_b20", 16'h0806, 16'h0800, 6, 16'd1, 32'hC0A80101, 48'h0,           32'hC0A8010A, 21, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[4] = mk("hlen8",     16'h0806, 16'h0800, 8, 16'd1, 32'hC0A80101, 48'h0,           32'hC0A8010A, 28, 0, 0, 0, 1, 0, 0, 0, 0, 2);
    vecs[5] = mk("oper3",     16'h0806, 16'h0800, 6, 16'd3, 32'hC0A80101, 48'h0,           32'hC0A8010A, 28, 0, 0, 0, 1, 0, 0, 0, 0, 3);
    vecs[6] = mk("ethtype",   16'h0800, 16'h0800, 6, 16'd1, 32'hC0A80101, 48'h0,           32'hC0A8010A, 28, 0, 0, 0, 1, 0, 0, 0, 0, 4);
    vecs[7] = mk("tuser",     16'h0806, 16'h0800, 6, 16'd1, 32'hC0A80101, 48'h0,           32'hC0A8010A, 28, 1, 0, 0, 0, 0, 0, 0, 0, 5);
    vecs[8] = mk("ptype",     16'h0806, 16'h86DD, 6, 16'd1, 32'hC0A80101, 48'h0,           32'hC0A8010A, 28, 0, 0, 0, 1, 0, 0, 0, 0, 6);
    vecs[9] = mk("early_b26", 16'h0806, 16'h0800, 6, 16'd2, 32'hC0A80101, 48'h0,           32'hC0A8010A, 27, 0, 0, 1, 0, 0, 0, 0, 0, 7);

    // Reset state
    #3;
    chk("rst_a_hdr_ready", 64'(a_hdr_ready), 64'd0);
    chk("rst_a_tready",    64'(a_tready), 64'd0);
    chk("rst_a_valid",     64'(a_m_valid), 64'd0);
    chk("rst_a_busy",      64'(a_busy), 64'd0);
    chk("rst_a_drop",      64'(a_drop), 64'd0);
    chk("rst_b_hdr_ready", 64'(b_hdr_ready), 64'd0);
    chk("rst_b_tpa",       64'(b_o_tpa), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_a_hdr_ready", 64'(a_hdr_ready), 64'd1);

    // Table-driven frames on instance A
    for (int k = 0; k < 10; k++) begin
      fill_frame(vecs[k].ptype, vecs[k].hlen, vecs[k].oper, vecs[k].spa, vecs[k].tha, vecs[k].tpa);
      a_hdr(vecs[k].et);
      a_payload(vecs[k].len, vecs[k].user);
      $display("vec %0d %s: valid=%0b early=%0b inv=%0b drop=%0d", k, vecs[k].name,
               a_m_valid, a_err_early, a_err_inv, a_drop);
      chk({vecs[k].name, "_valid"}, 64'(a_m_valid), 64'(vecs[k].e_valid));
      chk({vecs[k].name, "_early"}, 64'(a_err_early), 64'(vecs[k].e_early));
      chk({vecs[k].name, "_inv"},   64'(a_err_inv), 64'(vecs[k].e_inv));
      chk({vecs[k].name, "_drop"},  64'(a_drop), 64'(vecs[k].e_drop));
      if (vecs[k].e_valid) begin
        chk({vecs[k].name, "_ip"},   64'(a_ip), 64'(vecs[k].e_ip));
        chk({vecs[k].name, "_mac"},  64'(a_mac), 64'(vecs[k].e_mac));
        chk({vecs[k].name, "_req"},  64'(a_req), 64'(vecs[k].e_req));
        chk({vecs[k].name, "_grat"}, 64'(a_grat), 64'(vecs[k].e_grat));
        chk({vecs[k].name, "_oper"}, 64'(a_o_oper), 64'(vecs[k].oper));
        chk({vecs[k].name, "_spa"},  64'(a_o_spa), 64'(vecs[k].spa));
        chk({vecs[k].name, "_tpa"},  64'(a_o_tpa), 64'(vecs[k].tpa));
        chk({vecs[k].name, "_tha"},  64'(a_o_tha), 64'(vecs[k].tha));
        chk({vecs[k].name, "_sha"},  64'(a_o_sha), 64'(SHA));
        chk({vecs[k].name, "_src"},  64'(a_o_src), 64'(SMAC));
        a_m_ready = 1'b1;
      end
      @(posedge clk); #1;
      a_m_ready = 1'b0;
      chk({vecs[k].name, "_pulse_end"}, 64'({a_err_early, a_err_inv, a_m_valid}), 64'd0);
    end

    // Instance B: 60-byte padded frame, output held under backpressure
    fill_frame(16'h0800, 6, 16'd1, 32'hC0A80105, 48'h0, LIP);
    b_hdr(16'h0806);
    b_payload(60, 0);
    $display("b frame0: valid=%0b tpa=%0h drop=%0d", b_m_valid, b_o_tpa, b_drop);
    chk("b0_valid", 64'(b_m_valid), 64'd1);
    chk("b0_tpa",   64'(b_o_tpa), 64'(LIP));
    chk("b0_spa",   64'(b_o_spa), 64'h0C0A80105);
    chk("b0_ip",    64'(b_ip), 64'd1);
    chk("b0_busy",  64'(b_busy), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("b0_hold_valid", 64'(b_m_valid), 64'd1);
      chk("b0_hold_tpa",   64'(b_o_tpa), 64'(LIP));
      chk("b0_hold_sha",   64'(b_o_sha), 64'(SHA));
      chk("b0_hold_hdr_ready", 64'(b_hdr_ready), 64'd0);
    end

    // Back-to-back: next header accepted in the consuming cycle
    b_hdr_valid = 1'b1; b_type = 16'h0806; b_dest = LMAC; b_src = SMAC; b_m_ready = 1'b1;
    @(negedge clk);
    chk("b2b_hdr_ready", 64'(b_hdr_ready), 64'd1);
    @(posedge clk); #1;
    b_hdr_valid = 1'b0; b_m_ready = 1'b0;
    chk("b2b_valid_cleared", 64'(b_m_valid), 64'd0);
    chk("b2b_busy", 64'(b_busy), 64'd1);

    // Filter drops on B: tpa 10.0.0.99, 2-bit counter saturates at 3
    fill_frame(16'h0800, 6, 16'd1, 32'hC0A80105, 48'h0, 32'h0A000063);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) b_hdr(16'h0806);
      b_payload(60, 0);
      exp_d = (k + 1 > 3) ? 3 : k + 1;
      $display("b filter %0d: valid=%0b err=%0b%0b drop=%0d", k, b_m_valid, b_err_early, b_err_inv, b_drop);
      chk("bf_valid", 64'(b_m_valid), 64'd0);
      chk("bf_err",   64'({b_err_early, b_err_inv}), 64'd0);
      chk("bf_drop",  64'(b_drop), 64'(exp_d));
    end

    // Reset during byte 10 of a frame on A, then a clean frame
    fill_frame(16'h0800, 6, 16'd1, 32'hC0A80101, 48'h0, LIP);
    a_hdr(16'h0806);
    for (int i = 0; i < 10; i++) a_beat(fb[i], 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_busy",   64'(a_busy), 64'd0);
    chk("mid_rst_tready", 64'(a_tready), 64'd0);
    chk("mid_rst_drop",   64'(a_drop), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_hdr(16'h0806);
    a_payload(28, 0);
    $display("post reset frame: valid=%0b tpa=%0h drop=%0d", a_m_valid, a_o_tpa, a_drop);
    chk("post_rst_valid", 64'(a_m_valid), 64'd1);
    chk("post_rst_tpa",   64'(a_o_tpa), 64'(LIP));
    chk("post_rst_req",   64'(a_req), 64'd1);
    chk("post_rst_drop",  64'(a_drop), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
